// File: rtl/pipe_hazard_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl_pkg
//   Shared definitions for the pipeline hazard scheduler:
//   - FSM state encodings (RUN / MEM_WAIT / MEM_ERR)
//   - the architectural zero register index
//   - the bundle of pipeline control outputs and its canonical values
//   - a small helper for register-match detection
// ---------------------------------------------------------------------------
package pipe_hazard_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_RUN      = 2'd0,
      ST_MEM_WAIT = 2'd1,
      ST_MEM_ERR  = 2'd2
   } state_e;

   // x0 is hardwired to zero, so a load into it never creates a dependency.
   localparam logic [4:0] REG_X0 = 5'd0;

   // Pipeline control outputs, grouped so each priority level is one constant.
   typedef struct packed {
      logic pc_write;
      logic if_id_write;
      logic if_id_flush;
      logic id_ex_bubble;
      logic pipe_hold;
   } ctl_t;

   // Held in reset: nothing advances, both front registers load NOPs.
   localparam ctl_t CTL_RESET = '{pc_write: 1'b0, if_id_write: 1'b0,
                                  if_id_flush: 1'b1, id_ex_bubble: 1'b1,
                                  pipe_hold: 1'b0};
   // Terminal error: the whole pipe is frozen.
   localparam ctl_t CTL_FROZEN = '{pc_write: 1'b0, if_id_write: 1'b0,
                                   if_id_flush: 1'b0, id_ex_bubble: 1'b0,
                                   pipe_hold: 1'b1};
   // Data memory busy: everything holds, no flush or bubble.
   localparam ctl_t CTL_MEM_HOLD = '{pc_write: 1'b0, if_id_write: 1'b0,
                                     if_id_flush: 1'b0, id_ex_bubble: 1'b0,
                                     pipe_hold: 1'b1};
   // Mispredict: redirect the PC and squash IF/ID and ID/EX.
   localparam ctl_t CTL_REDIRECT = '{pc_write: 1'b1, if_id_write: 1'b1,
                                     if_id_flush: 1'b1, id_ex_bubble: 1'b1,
                                     pipe_hold: 1'b0};
   // Load-use: keep PC and IF/ID, insert a bubble into EX.
   localparam ctl_t CTL_LOAD_USE = '{pc_write: 1'b0, if_id_write: 1'b0,
                                     if_id_flush: 1'b0, id_ex_bubble: 1'b1,
                                     pipe_hold: 1'b0};
   // Normal flow.
   localparam ctl_t CTL_RUN = '{pc_write: 1'b1, if_id_write: 1'b1,
                                if_id_flush: 1'b0, id_ex_bubble: 1'b0,
                                pipe_hold: 1'b0};

   // True when a source operand is actually read and names register rd.
   function automatic logic reg_hit(input logic       used,
                                    input logic [4:0] rs,
                                    input logic [4:0] rd);
      return used && (rs == rd);
   endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// ---------------------------------------------------------------------------
// sat_counter
//   Up-counter that sticks at all-ones instead of wrapping.
//   Ports:
//     clk    rising-edge clock
//     rst_n  asynchronous active-low reset, clears the count
//     inc    count enable for this cycle
//     q      current count (W bits)
// ---------------------------------------------------------------------------
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         inc,
   output logic [W-1:0] q
);

   localparam logic [W-1:0] CNT_MAX = {W{1'b1}};

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (inc && (cnt_q != CNT_MAX)) begin
         cnt_d = cnt_q + W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign q = cnt_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl
//   Hazard scheduler for the 5-stage pipeline around the ID decoder.
//   Detects load-use hazards (one-cycle bubble), squashes IF/ID and ID/EX on
//   an EX mispredict, freezes the pipe while data memory is busy (with a
//   timeout into a sticky error state), and keeps saturating stall/flush
//   counters. Control outputs are combinational from state and inputs.
//
//   Ports:
//     clk, rst_n                      clock, async active-low reset
//     id_rs1/id_rs2, *_used           source registers of the ID instruction
//     ex_memread, ex_rd               load in EX and its destination
//     ex_mispredict                   EX resolved a wrong fetch path
//     mem_req, dmem_ready             MEM stage access and its completion
//     pc_write, if_id_write           PC / IF/ID enables
//     if_id_flush, id_ex_bubble       NOP injection into IF/ID / ID/EX
//     pipe_hold                       freeze ID/EX, EX/MEM, MEM/WB
//     mem_err                         sticky data-memory timeout flag
//     stall_cycles, flush_count       saturating performance counters
// ---------------------------------------------------------------------------
module pipe_hazard_ctrl
   import pipe_hazard_ctrl_pkg::*;
#(
   parameter int MEM_TIMEOUT = 64,
   parameter int TO_W        = 7,
   parameter int CNT_W       = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [4:0]       id_rs1,
   input  logic [4:0]       id_rs2,
   input  logic             id_rs1_used,
   input  logic             id_rs2_used,
   input  logic             ex_memread,
   input  logic [4:0]       ex_rd,
   input  logic             ex_mispredict,
   input  logic             mem_req,
   input  logic             dmem_ready,
   output logic             pc_write,
   output logic             if_id_write,
   output logic             if_id_flush,
   output logic             id_ex_bubble,
   output logic             pipe_hold,
   output logic             mem_err,
   output logic [CNT_W-1:0] stall_cycles,
   output logic [CNT_W-1:0] flush_count
);

   localparam logic [TO_W-1:0] TO_MAX = TO_W'(MEM_TIMEOUT);

   state_e          state_q;
   state_e          state_d;
   logic [TO_W-1:0] to_cnt_q;
   logic [TO_W-1:0] to_cnt_d;

   logic mem_stall;
   logic load_use;
   logic flush_evt;
   logic stall_evt;
   ctl_t ctl;

   // ------------------------------------------------------------------
   // Hazard detection
   // ------------------------------------------------------------------
   always_comb begin
      mem_stall = mem_req && !dmem_ready;
      load_use  = ex_memread && (ex_rd != REG_X0) &&
                  (reg_hit(id_rs1_used, id_rs1, ex_rd) ||
                   reg_hit(id_rs2_used, id_rs2, ex_rd));
   end

   // ------------------------------------------------------------------
   // Output priority. A memory stall masks mispredict and load-use because
   // EX is frozen and presents the same instruction again on release.
   // A mispredict masks load-use because the dependent ID instruction is
   // squashed anyway.
   // ------------------------------------------------------------------
   always_comb begin
      ctl       = CTL_RUN;
      flush_evt = 1'b0;
      if (!rst_n) begin
         ctl = CTL_RESET;
      end else if (state_q == ST_MEM_ERR) begin
         ctl = CTL_FROZEN;
      end else if (mem_stall) begin
         ctl = CTL_MEM_HOLD;
      end else if (ex_mispredict) begin
         ctl       = CTL_REDIRECT;
         flush_evt = 1'b1;
      end else if (load_use) begin
         ctl = CTL_LOAD_USE;
      end
   end

   // ------------------------------------------------------------------
   // FSM and timeout counter next-state
   // ------------------------------------------------------------------
   always_comb begin
      state_d  = state_q;
      to_cnt_d = to_cnt_q;
      case (state_q)
         ST_RUN: begin
            if (mem_stall) begin
               state_d  = ST_MEM_WAIT;
               to_cnt_d = TO_W'(1);
            end
         end
         ST_MEM_WAIT: begin
            // Release whenever the stall condition is gone; the release
            // cycle itself is serviced normally by the priority logic.
            if (!mem_stall) begin
               state_d  = ST_RUN;
               to_cnt_d = '0;
            end else if (to_cnt_q == TO_MAX) begin
               state_d = ST_MEM_ERR;
            end else begin
               to_cnt_d = to_cnt_q + TO_W'(1);
            end
         end
         ST_MEM_ERR: begin
            state_d = ST_MEM_ERR;
         end
         default: begin
            state_d  = ST_RUN;
            to_cnt_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_RUN;
         to_cnt_q <= '0;
      end else begin
         state_q  <= state_d;
         to_cnt_q <= to_cnt_d;
      end
   end

   // ------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------
   assign pc_write     = ctl.pc_write;
   assign if_id_write  = ctl.if_id_write;
   assign if_id_flush  = ctl.if_id_flush;
   assign id_ex_bubble = ctl.id_ex_bubble;
   assign pipe_hold    = ctl.pipe_hold;
   assign mem_err      = rst_n && (state_q == ST_MEM_ERR);

   // ------------------------------------------------------------------
   // Performance counters
   // ------------------------------------------------------------------
   assign stall_evt = rst_n && !ctl.pc_write;

   sat_counter #(
      .W (CNT_W)
   ) u_stall_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (stall_evt),
      .q     (stall_cycles)
   );

   sat_counter #(
      .W (CNT_W)
   ) u_flush_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (flush_evt),
      .q     (flush_count)
   );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipe_hazard_ctrl
//   Scoreboard bench: each cycle the stimulus is driven, a behavioural model
//   predicts the outputs for that cycle and pushes them to a queue; the
//   entry is popped and compared against the DUT on the falling edge.
// ---------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;

   localparam int MEM_TIMEOUT = 4;
   localparam int TO_W        = 3;
   localparam int CNT_W       = 4;
   localparam int CNT_SAT     = (1 << CNT_W) - 1;

   logic             clk = 1'b0;
   logic             rst_n;
   logic [4:0]       id_rs1, id_rs2, ex_rd;
   logic             id_rs1_used, id_rs2_used;
   logic             ex_memread, ex_mispredict, mem_req, dmem_ready;
   logic             pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_hold;
   logic             mem_err;
   logic [CNT_W-1:0] stall_cycles, flush_count;

   always #5 clk = ~clk;

   pipe_hazard_ctrl #(
      .MEM_TIMEOUT (MEM_TIMEOUT),
      .TO_W        (TO_W),
      .CNT_W       (CNT_W)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .id_rs1        (id_rs1),
      .id_rs2        (id_rs2),
      .id_rs1_used   (id_rs1_used),
      .id_rs2_used   (id_rs2_used),
      .ex_memread    (ex_memread),
      .ex_rd         (ex_rd),
      .ex_mispredict (ex_mispredict),
      .mem_req       (mem_req),
      .dmem_ready    (dmem_ready),
      .pc_write      (pc_write),
      .if_id_write   (if_id_write),
      .if_id_flush   (if_id_flush),
      .id_ex_bubble  (id_ex_bubble),
      .pipe_hold     (pipe_hold),
      .mem_err       (mem_err),
      .stall_cycles  (stall_cycles),
      .flush_count   (flush_count)
   );

   // Expected outputs for one cycle; ctl = {pc, ifw, flush, bubble, hold}.
   typedef struct {
      logic [4:0] ctl;
      logic       err;
      int         stall;
      int         flush;
   } exp_t;

   exp_t sb_q[$];
   int   total = 0;
   int   bad   = 0;
   int   cyc   = 0;

   // Model state: 0 = RUN, 1 = MEM_WAIT, 2 = MEM_ERR
   int m_state = 0, m_to = 0, m_stall = 0, m_flush = 0;
   int n_state, n_to, n_stall, n_flush;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
      end
   endtask

   task automatic set_in(input logic mr, input logic [4:0] rd,
                         input logic [4:0] r1, input logic u1,
                         input logic [4:0] r2, input logic u2,
                         input logic mis, input logic mreq, input logic rdy);
      ex_memread    = mr;
      ex_rd         = rd;
      id_rs1        = r1;
      id_rs1_used   = u1;
      id_rs2        = r2;
      id_rs2_used   = u2;
      ex_mispredict = mis;
      mem_req       = mreq;
      dmem_ready    = rdy;
   endtask

   // One clock cycle: inputs are already applied; predict, compare, advance.
   task automatic cycle();
      exp_t e;
      exp_t g;
      logic ms, lu;
      if (!rst_n) begin
         m_state = 0; m_to = 0; m_stall = 0; m_flush = 0;
      end
      ms = mem_req && !dmem_ready;
      lu = ex_memread && (ex_rd != 5'd0) &&
           ((id_rs1_used && (id_rs1 == ex_rd)) || (id_rs2_used && (id_rs2 == ex_rd)));
      e.err   = rst_n && (m_state == 2);
      e.stall = m_stall;
      e.flush = m_flush;
      n_stall = m_stall;
      n_flush = m_flush;
      if (!rst_n)              e.ctl = 5'b00110;
      else if (m_state == 2)   e.ctl = 5'b00001;
      else if (ms)             e.ctl = 5'b00001;
      else if (ex_mispredict) begin
         e.ctl = 5'b11110;
         if (n_flush < CNT_SAT) n_flush++;
      end
      else if (lu)             e.ctl = 5'b00010;
      else                     e.ctl = 5'b11000;
      if (rst_n && !e.ctl[4] && n_stall < CNT_SAT) n_stall++;
      n_state = m_state;
      n_to    = m_to;
      if (!rst_n) begin
         n_state = 0; n_to = 0; n_stall = 0; n_flush = 0;
      end else if (m_state == 0 && ms) begin
         n_state = 1; n_to = 1;
      end else if (m_state == 1) begin
         if (!ms) begin n_state = 0; n_to = 0; end
         else if (m_to == MEM_TIMEOUT) n_state = 2;
         else n_to = m_to + 1;
      end
      sb_q.push_back(e);

      @(negedge clk);
      g.ctl   = {pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_hold};
      g.err   = mem_err;
      g.stall = int'(stall_cycles);
      g.flush = int'(flush_count);
      $display("cyc %0d rst_n=%b mr=%b rd=%0d rs1=%0d/%b rs2=%0d/%b mis=%b req=%b rdy=%b -> ctl=%b err=%b stall=%0d flush=%0d",
               cyc, rst_n, ex_memread, ex_rd, id_rs1, id_rs1_used, id_rs2, id_rs2_used,
               ex_mispredict, mem_req, dmem_ready, g.ctl, g.err, g.stall, g.flush);
      if (sb_q.size() == 0) begin
         check("sb_empty", 1, 0);
      end else begin
         e = sb_q.pop_front();
         check("ctl",   32'(g.ctl),   32'(e.ctl));
         check("err",   32'(g.err),   32'(e.err));
         check("stall", g.stall,      e.stall);
         check("flush", g.flush,      e.flush);
      end

      @(posedge clk);
      m_state = n_state; m_to = n_to; m_stall = n_stall; m_flush = n_flush;
      cyc++;
      #1;
   endtask

   task automatic idle();
      set_in(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      idle();
      cycle();
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n = 1'b0;
      idle();
      #1;
      // Reset state
      cycle();
      check("rst_flush", 32'(if_id_flush), 32'd1);
      rst_n = 1'b1;
      idle(); cycle();

      // 1. lw x5 in EX, add x6,x5,x1 in ID
      set_in(1'b1, 5'd5, 5'd5, 1'b1, 5'd1, 1'b1, 1'b0, 1'b0, 1'b1); cycle();
      idle(); cycle();
      check("lu_stall_cnt", 32'(stall_cycles), 32'd1);

      // rs2 dependency counts; an unused rs2 match does not
      set_in(1'b1, 5'd7, 5'd2, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b1); cycle();
      set_in(1'b1, 5'd7, 5'd2, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, 1'b1); cycle();
      // no load in EX: no hazard
      set_in(1'b0, 5'd7, 5'd7, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b1); cycle();

      // 2. x0 is exempt
      set_in(1'b1, 5'd0, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1); cycle();

      // 3. mispredict coincident with load-use
      do_reset();
      set_in(1'b1, 5'd5, 5'd5, 1'b1, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1); cycle();
      idle(); cycle();
      check("mis_flush_cnt", 32'(flush_count), 32'd1);
      check("mis_stall_cnt", 32'(stall_cycles), 32'd0);

      // 4. memory stall for 3 cycles, ready on the 4th
      do_reset();
      for (int i = 0; i < 3; i++) begin
         set_in(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0); cycle();
      end
      set_in(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1); cycle();
      idle(); cycle();
      check("mem_stall_cnt", 32'(stall_cycles), 32'd3);

      // Mispredict during a stall is held, then acted on at release
      set_in(1'b1, 5'd4, 5'd4, 1'b1, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0); cycle();
      set_in(1'b1, 5'd4, 5'd4, 1'b1, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1); cycle();
      idle(); cycle();

      // 5. timeout into MEM_ERR, then reset while in it
      do_reset();
      for (int i = 0; i < 8; i++) begin
         set_in(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0); cycle();
      end
      idle(); cycle();
      check("err_sticky", 32'(mem_err), 32'd1);
      do_reset();
      check("err_cleared", 32'(mem_err), 32'd0);
      idle(); cycle();

      // 6. counter saturation
      do_reset();
      for (int i = 0; i < 20; i++) begin
         set_in(1'b1, 5'd9, 5'd9, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1); cycle();
      end
      idle(); cycle();
      check("stall_sat", 32'(stall_cycles), 32'(CNT_SAT));

      // Random traffic with small register space to provoke collisions
      do_reset();
      for (int i = 0; i < 300; i++) begin
         rst_n = ($urandom_range(0, 63) != 0);
         set_in(1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
                5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                ($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)),
                ($urandom_range(0, 3) != 0));
         cycle();
      end
      rst_n = 1'b1;
      idle(); cycle();

      check("sb_drained", 32'(sb_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Absolute guard against a hung run.
   initial begin
      #200000;
      $display("FAIL watchdog cyc=%0d got=running exp=finished", cyc);
      $fatal(1, "watchdog expired");
   end

endmodule
